// File: rtl/sram_host_arb.sv
// Two-host (instruction/data) arbiter in front of a single-port SRAM with
// 1-cycle read latency; round-robin on contention, error response for misses.

module sram_host_arb_chk (
  input logic clk,
  input logic rst_n,
  input logic tag_valid,
  input logic tag_err,
  input logic mem_rvalid,
  input logic gnt_instr,
  input logic gnt_data
);
  // A granted in-range access must be answered by the SRAM one cycle later.
  assert property (@(posedge clk) disable iff (!rst_n)
    (tag_valid && !tag_err) |-> mem_rvalid)
    else $error("sram_host_arb: SRAM did not return rvalid for a granted access");

  // Never grant both hosts in one cycle.
  assert property (@(posedge clk) disable iff (!rst_n) !(gnt_instr && gnt_data))
    else $error("sram_host_arb: dual grant");
endmodule

module sram_host_arb #(
  parameter int unsigned MemSize  = 65536,
  parameter logic [31:0] MemStart = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] AddrMask = ~(32'(MemSize) - 32'd1);

  function automatic logic in_range(input logic [31:0] addr);
    return (addr & AddrMask) == MemStart;
  endfunction

  logic       last_data;
  logic       tag_valid;
  logic       tag_host;
  logic       tag_err;
  logic [7:0] err_cnt;

  logic grant_instr;
  logic grant_data;
  logic grant_any;
  logic win_in_range;

  // Round-robin arbitration; the pointer favours the host not granted last.
  always_comb begin
    grant_instr  = 1'b0;
    grant_data   = 1'b0;
    win_in_range = 1'b0;
    if (rst_ni) begin
      grant_instr = instr_req_i && (!data_req_i || last_data);
      grant_data  = data_req_i && (!instr_req_i || !last_data);
    end else begin
      grant_instr = 1'b0;
      grant_data  = 1'b0;
    end
    grant_any = grant_instr || grant_data;
    if (grant_data) begin
      win_in_range = in_range(data_addr_i);
    end else begin
      win_in_range = in_range(instr_addr_i);
    end
  end

  assign instr_gnt_o = grant_instr;
  assign data_gnt_o  = grant_data;

  // SRAM request mux: only an in-range winner reaches the device.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    case ({grant_data, grant_instr})
      2'b10: begin
        if (win_in_range) begin
          mem_req_o   = 1'b1;
          mem_we_o    = data_we_i;
          mem_be_o    = data_be_i;
          mem_addr_o  = data_addr_i;
          mem_wdata_o = data_wdata_i;
        end else begin
          mem_req_o = 1'b0;
        end
      end
      2'b01: begin
        if (win_in_range) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b0;
          mem_be_o    = 4'hF;
          mem_addr_o  = instr_addr_i;
          mem_wdata_o = 32'h0;
        end else begin
          mem_req_o = 1'b0;
        end
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

  // Response tag, round-robin pointer and sticky out-of-range counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_data <= 1'b1;
      tag_valid <= 1'b0;
      tag_host  <= 1'b0;
      tag_err   <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      tag_valid <= grant_any;
      tag_host  <= grant_data;
      tag_err   <= grant_any && !win_in_range;
      if (grant_any) begin
        last_data <= grant_data;
      end
      if (grant_any && !win_in_range && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Route the single response to the tagged host; errors return zero data.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_err_o    = 1'b0;
    instr_rdata_o  = 32'h0;
    data_rvalid_o  = 1'b0;
    data_err_o     = 1'b0;
    data_rdata_o   = 32'h0;
    if (tag_valid && tag_host) begin
      data_rvalid_o = 1'b1;
      data_err_o    = tag_err;
      data_rdata_o  = tag_err ? 32'h0 : mem_rdata_i;
    end else if (tag_valid) begin
      instr_rvalid_o = 1'b1;
      instr_err_o    = tag_err;
      instr_rdata_o  = tag_err ? 32'h0 : mem_rdata_i;
    end else begin
      instr_rvalid_o = 1'b0;
      data_rvalid_o  = 1'b0;
    end
  end

  sram_host_arb_chk u_chk (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .tag_valid  (tag_valid),
    .tag_err    (tag_err),
    .mem_rvalid (mem_rvalid_i),
    .gnt_instr  (grant_instr),
    .gnt_data   (grant_data)
  );

endmodule

// File: tb/tb_sram_host_arb.sv
// Scoreboard bench for sram_host_arb: directed scenarios followed by a random
// request stream, checked against a transaction-level model and an SRAM model.

module tb_sram_host_arb;
  localparam int unsigned MEM_SIZE  = 65536;
  localparam logic [31:0] MEM_START = 32'h0000_0000;
  localparam logic [31:0] MASK      = ~(MEM_SIZE - 32'd1);

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  sram_host_arb #(.MemSize(MEM_SIZE), .MemStart(MEM_START)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        host;   // 1 = data port
    logic        err;
    logic        wr;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic       m_last_data = 1'b1;
  int         m_err_cnt   = 0;
  logic [31:0] ref_mem  [int];
  logic [31:0] sram_mem [int];

  function automatic logic [31:0] pattern(input int idx);
    if (idx == 32'h20) return 32'hDEAD_BEEF;
    return (idx * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 32'($urandom) | 32'h0001_0000;
    return {20'h0, 12'($urandom)};
  endfunction

  // SRAM device model: 1-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    int idx;
    logic [31:0] w;
    idx = int'(mem_addr_o[15:2]);
    w   = sram_mem.exists(idx) ? sram_mem[idx] : pattern(idx);
    mem_rvalid_i <= mem_req_o;
    if (mem_req_o && mem_we_o) begin
      for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
      sram_mem[idx] = w;
      mem_rdata_i <= 32'h0;
    end else if (mem_req_o) begin
      mem_rdata_i <= w;
    end else begin
      mem_rdata_i <= 32'h0;
    end
  end

  // Response monitor: pops the expected response due this cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] got, want;
    logic [31:0] rd_tag, rd_other;
    got = {instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o};
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      want = e.host ? {2'b01, 1'b0, e.err} : {2'b10, e.err, 1'b0};
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL rsp_flags cyc=%0d got=%b want=%b", cyc, got, want);
      end
      rd_tag   = e.host ? data_rdata_o : instr_rdata_o;
      rd_other = e.host ? instr_rdata_o : data_rdata_o;
      if (!e.wr) begin
        compared++;
        if (rd_tag !== e.rdata || rd_other !== 32'h0) begin
          mismatched++;
          $display("FAIL rsp_rdata cyc=%0d got=%h/%h want=%h/0", cyc, rd_tag, rd_other, e.rdata);
        end
      end
    end else if (got != 4'b0000) begin
      compared++;
      mismatched++;
      $display("FAIL spurious_rsp cyc=%0d got=%b want=0000", cyc, got);
    end
  end

  // One cycle of requests; entered and left at 1 time unit after a rising edge.
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd);
    logic win_i, win_d, inr;
    logic [31:0] addr, w;
    logic [69:0] exp_mem, got_mem;
    int idx;
    exp_t e;
    instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_we_i = dw; data_be_i = db; data_addr_i = da; data_wdata_i = dd;
    win_d = dr && (!ir || !m_last_data);
    win_i = ir && !win_d;
    exp_mem = 70'h0;
    if (win_i || win_d) begin
      addr = win_d ? da : ia;
      inr  = (addr & MASK) == MEM_START;
      idx  = int'(addr[15:2]);
      w    = ref_mem.exists(idx) ? ref_mem[idx] : pattern(idx);
      e.host = win_d; e.err = !inr; e.wr = win_d && dw;
      e.rdata = inr ? w : 32'h0; e.due = cyc + 1;
      sbq.push_back(e);
      if (inr && win_d && dw) begin
        for (int b = 0; b < 4; b++) if (db[b]) w[8*b +: 8] = dd[8*b +: 8];
        ref_mem[idx] = w;
      end
      if (!inr && m_err_cnt < 255) m_err_cnt++;
      if (inr) exp_mem = win_d ? {1'b1, dw, db, da, dd} : {1'b1, 1'b0, 4'hF, ia, 32'h0};
      m_last_data = win_d;
    end
    @(negedge clk);
    compared++;
    if ({instr_gnt_o, data_gnt_o} !== {win_i, win_d}) begin
      mismatched++;
      $display("FAIL grant cyc=%0d got=%b%b want=%b%b", cyc, instr_gnt_o, data_gnt_o, win_i, win_d);
    end
    got_mem = {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
    compared++;
    if (got_mem !== exp_mem) begin
      mismatched++;
      $display("FAIL mem_port cyc=%0d got=%h want=%h", cyc, got_mem, exp_mem);
    end
    @(posedge clk);
    #1;
    compared++;
    if (int'(dut.err_cnt) != m_err_cnt) begin
      mismatched++;
      $display("FAIL err_cnt got=%0d want=%0d", dut.err_cnt, m_err_cnt);
    end
  endtask

  // Reset with both hosts requesting; outputs must stay quiet and pending responses drop.
  task automatic do_reset();
    rst_ni = 1'b0;
    sbq.delete();
    instr_req_i = 1'b1; instr_addr_i = 32'h40;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h44; data_wdata_i = 32'h0;
    @(negedge clk);
    compared++;
    if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, mem_req_o} !== 7'b0
        || dut.err_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_outputs gnt=%b%b rv=%b%b err=%b%b mreq=%b cnt=%0d want all 0",
               instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o,
               mem_req_o, dut.err_cnt);
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    instr_req_i = 1'b0; data_req_i = 1'b0;
    m_last_data = 1'b1;
    m_err_cnt = 0;
  endtask

  initial begin
    rst_ni = 1'b0;
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0; data_addr_i = 32'h0; data_wdata_i = 32'h0;
    @(posedge clk);
    #1;
    do_reset();
    // Continuous contention straight out of reset: I, D, I, D.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h200 + 32'(4*i), 1'b1, 1'b0, 4'hF, 32'h300 + 32'(4*i), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_reset();
    drive(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'h0000_1234);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    // Reset lands in the cycle the instruction response would appear.
    drive(1'b1, 32'h84, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_reset();
    drive(1'b1, 32'h88, 1'b1, 1'b0, 4'hF, 32'h8C, 32'h0);
    drive(1'b1, 32'h90, 1'b1, 1'b1, 4'hF, 32'h94, 32'hCAFE_F00D);
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), rand_addr(), 32'($urandom));
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL missing_rsp got=%0d outstanding want=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sram_host_arb.md
SRAM_HOST_ARB -- requirements
Module: sram_host_arb

Interface
REQ-001 SHALL have parameter MemSize, default 65536, meaning SRAM size in bytes (power of two).
REQ-002 SHALL have parameter MemStart, default 32'h00000000, meaning SRAM base address (aligned to MemSize).
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have instr_req_i in 1, instr_addr_i in 32, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32, instr_err_o out 1, meaning the core instruction host port.
REQ-006 SHALL have data_req_i in 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32, data_err_o out 1, meaning the core data host port.
REQ-007 SHALL have mem_req_o out 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32, mem_rvalid_i in 1, mem_rdata_i in 32, meaning the single-port SRAM device port (fixed 1-cycle read latency).

Function
REQ-008 Address decode: in range iff (addr & ~(MemSize-1)) == MemStart.
REQ-009 Arbitration combinational per cycle; at most one host granted per cycle.
REQ-010 Only one host requesting -> that host wins.
REQ-011 Both requesting -> round-robin: winner is the host not granted most recently; 1-bit pointer last_data updates on every grant.
REQ-012 Pointer reset value: last_data=1 (instruction port wins first contention).
REQ-013 Winner's gnt_o asserted same cycle as its req_i; loser's gnt_o low; request not accepted until gnt seen.
REQ-014 Winner in range: mem_req_o=1; mem_addr_o=winner addr; data winner drives mem_we_o/be/wdata; instruction winner drives mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-015 Winner out of range: still granted; mem_req_o=0; error response issued (REQ-018).
REQ-016 No winner: mem_req_o=0 and all mem_* outputs 0.
REQ-017 Response tag register (valid, host, err) loaded on every grant, cleared when no grant; rvalid to that host exactly 1 cycle after grant.
REQ-018 rvalid_o to tagged host = tag.valid; rdata_o = tag.err ? 0 : mem_rdata_i; err_o = tag.err; non-tagged host: rvalid/err/rdata all 0.
REQ-019 Data writes SHALL also receive rvalid (rdata 0 content don't-care, err per decode).
REQ-020 Back-to-back grants every cycle allowed, including alternating hosts; responses strictly in grant order.
REQ-021 tag.valid && !tag.err && !mem_rvalid_i SHALL raise a simulation assertion (protocol violation); outputs still follow REQ-018.
REQ-022 Grant and response same cycle for different hosts allowed (pipelined).
REQ-023 Sticky counter err_cnt (8 bit, saturating at 255, internal, observable hierarchically) increments per out-of-range grant.

Reset
REQ-024 rst_ni low SHALL asynchronously clear tag register, err_cnt, set last_data=1.
REQ-025 During reset all gnt/rvalid/err outputs and mem_req_o SHALL be 0.
REQ-026 Reset mid-transaction: pending response dropped, no rvalid after reset release.
REQ-027 First grant possible in the first clock cycle after rst_ni deasserts.

Verification
REQ-028 Instr only, addr 0x80, mem_rdata 0xDEADBEEF -> instr_gnt_o same cycle, instr_rvalid_o next cycle with rdata 0xDEADBEEF, err 0.
REQ-029 Both requesting continuously 4 cycles after reset -> grants I,D,I,D; rvalids follow one cycle later in same order.
REQ-030 Data write addr 0x100, be 4'b0011, wdata 0x1234 -> mem_we_o=1, mem_be_o=4'b0011, data_rvalid_o next cycle, err 0.
REQ-031 Data read addr 0x0001_0000 (MemSize 64 KiB) -> data_gnt_o=1, mem_req_o=0, next cycle data_rvalid_o=1, data_err_o=1, rdata 0, err_cnt=1.
REQ-032 Assert rst_ni low the cycle after an instr grant -> no instr_rvalid_o after release; next contention grants instruction port first.
REQ-033 Random req/addr stream 10k cycles with scoreboard -> every grant gets exactly one rvalid, correct host, in order, no dual grant.
